// File: rtl/decode_scoreboard_pkg.sv
// Shared definitions for the decode hazard scoreboard: result classes, the zero
// register and entry field width helpers.
package decode_scoreboard_pkg;

    localparam int unsigned ZERO          = 0;
    localparam int unsigned ENTRY_VALID_W = 1;

    typedef enum logic [1:0] {
        RC_ALU  = 2'd0,
        RC_LOAD = 2'd1,
        RC_MUL  = 2'd2
    } res_class_e;

    // Countdown field must hold the largest initial value of any result class.
    function automatic int unsigned cnt_width(input int unsigned load_ready,
                                              input int unsigned mul_lat);
        int unsigned mx;
        mx = load_ready;
        if (mul_lat > 0 && (mul_lat - 1) > mx) mx = mul_lat - 1;
        return (mx == 0) ? 1 : $clog2(mx + 1);
    endfunction

endpackage

// File: rtl/decode_scoreboard_match.sv
// sb_match: youngest-entry priority match of one source operand against all
// in-flight writers, yielding a hazard flag or a forward select.
module sb_match
    import decode_scoreboard_pkg::*;
#(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned SEL_W  = 3
) (
    input  logic [ADDR_W-1:0]       src_addr_i,
    input  logic                    src_used_i,
    input  logic [DEPTH-1:0]        ent_valid_i,
    input  logic [DEPTH*ADDR_W-1:0] ent_addr_i,
    input  logic [DEPTH-1:0]        ent_ready_i,
    output logic                    hazard_o,
    output logic [SEL_W-1:0]        fwd_sel_o
);

    logic found;

    always_comb begin
        found     = 1'b0;
        hazard_o  = 1'b0;
        fwd_sel_o = '0;
        if (src_used_i && src_addr_i != ADDR_W'(ZERO)) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (!found && ent_valid_i[i] &&
                    ent_addr_i[i*ADDR_W +: ADDR_W] == src_addr_i) begin
                    found = 1'b1;
                    if (ent_ready_i[i]) fwd_sel_o = SEL_W'(i + 1);
                    else                hazard_o  = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/decode_scoreboard.sv
// Decode-stage hazard scoreboard: tracks in-flight register writes with a
// readiness countdown; optional multi-cycle mul tracking via DECODE_SB_MUL_EN.
module decode_scoreboard
    import decode_scoreboard_pkg::*;
#(
    parameter  int unsigned ADDR_W     = 5,
    parameter  int unsigned DEPTH      = 4,
    parameter  int unsigned LOAD_READY = 1,
    parameter  int unsigned MUL_LAT    = 4,
    localparam int unsigned SEL_W      = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic              flush,
    input  logic [ADDR_W-1:0] id_rs_addr,
    input  logic [ADDR_W-1:0] id_rt_addr,
    input  logic              id_reads_rs,
    input  logic              id_reads_rt,
    input  logic              id_reg_we,
    input  logic [ADDR_W-1:0] id_write_addr,
    input  logic              id_is_load,
    input  logic              id_is_mul,
    output logic              stall,
    output logic              issue,
    output logic [SEL_W-1:0]  rs_fwd_sel,
    output logic [SEL_W-1:0]  rt_fwd_sel,
    output logic              mul_busy
);

    localparam int unsigned CNT_W = cnt_width(LOAD_READY, MUL_LAT);

    logic [DEPTH*ENTRY_VALID_W-1:0] valid_q, valid_d;
    logic [DEPTH*ADDR_W-1:0]        addr_q, addr_d;
    logic [DEPTH*CNT_W-1:0]         cnt_q, cnt_d;
    logic [DEPTH-1:0]               ready;
    logic                           rs_hazard, rt_hazard, mul_stall;
    res_class_e                     cls;
    logic [CNT_W-1:0]               init_cnt;

`ifdef DECODE_SB_MUL_EN
    logic [CNT_W-1:0] mul_cnt_q, mul_cnt_d;

    always_comb begin
        cls = id_is_load ? RC_LOAD : (id_is_mul ? RC_MUL : RC_ALU);
        if (issue && id_is_mul)     mul_cnt_d = CNT_W'(MUL_LAT - 1);
        else if (mul_cnt_q != '0)   mul_cnt_d = mul_cnt_q - CNT_W'(1);
        else                        mul_cnt_d = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) mul_cnt_q <= '0;
        else     mul_cnt_q <= mul_cnt_d;
    end

    assign mul_busy  = (mul_cnt_q != '0);
    assign mul_stall = id_is_mul & mul_busy;
`else
    logic unused_is_mul;
    assign unused_is_mul = id_is_mul;
    assign cls           = id_is_load ? RC_LOAD : RC_ALU;
    assign mul_busy      = 1'b0;
    assign mul_stall     = 1'b0;
`endif

    always_comb begin
        case (cls)
            RC_LOAD: init_cnt = CNT_W'(LOAD_READY);
            RC_MUL:  init_cnt = CNT_W'(MUL_LAT - 1);
            default: init_cnt = '0;
        endcase
    end

    assign stall = id_valid & ~flush & (rs_hazard | rt_hazard | mul_stall);
    assign issue = id_valid & ~flush & ~stall;

    // Entry 0 takes the issuing writer (or a bubble); older entries shift up
    // with their countdown saturating at zero.
    always_comb begin
        valid_d = '0;
        addr_d  = '0;
        cnt_d   = '0;
        ready   = '0;
        if (issue && id_reg_we && id_write_addr != ADDR_W'(ZERO)) begin
            valid_d[0]          = 1'b1;
            addr_d[ADDR_W-1:0]  = id_write_addr;
            cnt_d[CNT_W-1:0]    = init_cnt;
        end
        for (int unsigned i = 1; i < DEPTH; i++) begin
            valid_d[i]                  = valid_q[i-1];
            addr_d[i*ADDR_W +: ADDR_W]  = addr_q[(i-1)*ADDR_W +: ADDR_W];
            cnt_d[i*CNT_W +: CNT_W]     = (cnt_q[(i-1)*CNT_W +: CNT_W] == '0) ? '0 :
                                          cnt_q[(i-1)*CNT_W +: CNT_W] - CNT_W'(1);
        end
        for (int unsigned i = 0; i < DEPTH; i++) begin
            ready[i] = (cnt_q[i*CNT_W +: CNT_W] == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            addr_q  <= '0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
        end
    end

    sb_match #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .SEL_W(SEL_W)) u_match_rs (
        .src_addr_i  (id_rs_addr),
        .src_used_i  (id_reads_rs),
        .ent_valid_i (valid_q),
        .ent_addr_i  (addr_q),
        .ent_ready_i (ready),
        .hazard_o    (rs_hazard),
        .fwd_sel_o   (rs_fwd_sel)
    );

    sb_match #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .SEL_W(SEL_W)) u_match_rt (
        .src_addr_i  (id_rt_addr),
        .src_used_i  (id_reads_rt),
        .ent_valid_i (valid_q),
        .ent_addr_i  (addr_q),
        .ent_ready_i (ready),
        .hazard_o    (rt_hazard),
        .fwd_sel_o   (rt_fwd_sel)
    );

endmodule

// File: doc/decode_scoreboard.md
# decode_scoreboard

Parametrised hazard scoreboard for the MIPS decode stage. It tracks every in-flight register write between decode and register-file writeback, with a per-entry countdown until its result can be forwarded. From that state it produces per-operand forward selects and a decode stall. It generalises fixed single-stage load-use detection to arbitrary pipeline depth, load latency and a multi-cycle non-pipelined multiplier.

## Interface
Parameters:
- ADDR_W, 5, register address width
- DEPTH, 4, tracked stages after decode (index 0 = EX output … DEPTH-1 = last stage before writeback); legal range DEPTH ≥ MUL_LAT and DEPTH > LOAD_READY
- LOAD_READY, 1, extra cycles before load data can be forwarded
- MUL_LAT, 4, multiplier latency in cycles (≥ 1)

Ports (one clock `clk`; `rst` is synchronous, active-high):
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- id_valid  in  1  decode holds a real instruction
- flush  in  1  squash the decode instruction this cycle
- id_rs_addr, id_rt_addr  in  ADDR_W  source registers
- id_reads_rs, id_reads_rt  in  1  source actually used
- id_reg_we  in  1  instruction writes a register
- id_write_addr  in  ADDR_W  destination register
- id_is_load, id_is_mul  in  1  result class
- stall  out  1  hold the PC and the IF/ID register, and inject a bubble
- issue  out  1  instruction accepted this cycle (`id_valid & ~flush & ~stall`)
- rs_fwd_sel, rt_fwd_sel  out  $clog2(DEPTH+1)  0 = register file; k = forward from stage k-1
- mul_busy  out  1  multiplier occupied

## Operation
- Entry i holds `{valid, addr, ready_cnt}`. Every cycle entries shift from i to i+1. `ready_cnt` decrements and saturates at 0. Entry DEPTH-1 drops off; the register file is write-before-read, so no further tracking is needed.
- Entry 0 next value:
  - If `issue & id_reg_we & (id_write_addr != 0)`: `{1, id_write_addr, init}`. `init` is LOAD_READY for a load, MUL_LAT-1 for a mul, and 0 otherwise.
  - Otherwise the entry is invalid (a bubble).
- Operand lookup (rs; rt is identical):
  - If `~id_reads_rs`, or rs == 0, or no valid entry matches: select = 0, no hazard.
  - Otherwise take the lowest matching index i (the youngest entry). If its `ready_cnt == 0`, select = i+1. Otherwise the operand hazard is asserted and select = 0.
- Multiplier counter: loaded with MUL_LAT-1 when a mul issues; decrements to 0 otherwise. `mul_busy = (cnt != 0)`.
- Stall: `stall = id_valid & ~flush & (rs_hazard | rt_hazard | (id_is_mul & mul_busy))`.
- Flush takes priority over stall: stall = 0, issue = 0, and a bubble enters entry 0. Entries already in flight are not cleared.
- Stalled instructions re-evaluate every cycle from the shifted state. No state is captured for them.

## Timing
- Reset: all entries invalid and the mul counter is 0. Therefore stall, issue, both selects and mul_busy read 0 on the first cycle after reset, for any inputs with `id_valid` = 0.
- All outputs are combinational from the registered state and the current decode inputs. Entry and counter updates take effect at the next rising edge.
- Dependency distance d cycles after the producer issues:
  - ALU producer: no stall; select = d.
  - Load producer: stall while d ≤ LOAD_READY; then select = d.
  - Mul producer: stall while d < MUL_LAT; then select = d.
- A producer older than DEPTH is read from the register file (select 0).
- Multiple matches: only the youngest entry counts, even when an older entry is already ready.
- Reset asserted mid-operation clears everything at the next edge, including pending mul results.

## Configuration
- `DECODE_SB_MUL_EN` defined: multi-cycle mul tracking as described, with counter and mul_busy.
- `DECODE_SB_MUL_EN` not defined:
  - `id_is_mul` is ignored and a mul is treated as an ALU result (init 0).
  - The counter is removed and mul_busy is tied to 0.
  - The MUL_LAT ≥ 1 / DEPTH ≥ MUL_LAT constraint does not apply.

## Structure
- The shared defines header holds:
  - entry field widths
  - result-class codes (ALU/LOAD/MUL)
  - the `ZERO` register constant
- Sub-module `sb_match`: combinational priority match of one source address against all entries, returning `{hazard, fwd_sel}`. It is instantiated twice, once for rs and once for rt.

## Test plan
- Defaults, `addu $3` then dependent `addu` reading $3 in the next cycle → stall = 0, rs_fwd_sel = 1.
- `lw $5` then dependent on $5 in the next cycle → stall = 1 for one cycle, then rs_fwd_sel = 2; issue asserted on the release cycle only.
- `mul $7` then a dependent reading $7 as rt → stall for 3 cycles, then rt_fwd_sel = 4. A back-to-back second mul (independent) → stall for 3 cycles while mul_busy = 1.
- Two writers of $4 at distances 1 (load) and 2 (ALU) → stall (the youngest entry wins), then select 2.
- Writes to $0 and reads of $0 → never tracked, never stall, select 0. Flush during a load-use stall → stall = 0 and issue = 0 that cycle.
- Reset asserted while a load and a mul are in flight → the next cycle has all outputs 0 and a dependent instruction issues with select 0. Re-run with `DECODE_SB_MUL_EN` undefined: mul consumer at distance 1 → no stall, select 1.
